// File: rtl/itu656_encoder.sv
// itu656_encoder: ITU-R BT.656 525/60 byte-stream generator.
// Builds EAV/SAV codes, blanking fill and line/field timing around
// a YCbCr 4:2:2 pixel source read one word per two output bytes.
// Ports:
//   iCLK, iRST        27 MHz byte clock, async active-high reset
//   iYCbCr, iDVAL     pixel word {Y, Cb/Cr} and its valid flag
//   oRequest          one-cycle read strobe, 2 cycles ahead of the C byte
//   oTD_DATA          BT.656 byte stream
//   oTV_X, oTV_Y      pixel index / line number of the current byte
//   oHS, oVS, oField  H region, V bit and F bit of the current byte
//   oUnderflow        sticky flag: a sampled pixel was not valid
`timescale 1ns/1ps

module itu656_encoder #(
   parameter int H_ACTIVE = 720,
   parameter int H_BLANK  = 268,
   parameter int V_TOTAL  = 525,
   parameter int F0_FIRST = 4,
   parameter int F1_FIRST = 266,
   parameter int ACT1     = 20,
   parameter int V2_FIRST = 264,
   parameter int ACT2     = 283
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic [15:0] iYCbCr,
   input  logic        iDVAL,
   output logic        oRequest,
   output logic [7:0]  oTD_DATA,
   output logic [9:0]  oTV_X,
   output logic [9:0]  oTV_Y,
   output logic        oHS,
   output logic        oVS,
   output logic        oField,
   output logic        oUnderflow
);

   localparam int SAV_POS  = 4 + H_BLANK;
   localparam int ACT_POS  = SAV_POS + 4;
   localparam int LINE_LEN = ACT_POS + 2 * H_ACTIVE;
   localparam int HW       = $clog2(LINE_LEN);

   localparam logic [HW-1:0] H_FILL = HW'(4);
   localparam logic [HW-1:0] H_SAV  = HW'(SAV_POS);
   localparam logic [HW-1:0] H_ACT  = HW'(ACT_POS);
   localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
   // C byte of pixel k sits at H_ACT+2k; its request leads by 2.
   localparam logic [HW-1:0] H_RQ0  = HW'(ACT_POS - 2);
   localparam logic [HW-1:0] H_RQN  = HW'(ACT_POS + 2 * H_ACTIVE - 4);

   localparam logic [9:0] L_F0   = 10'(F0_FIRST);
   localparam logic [9:0] L_F1   = 10'(F1_FIRST);
   localparam logic [9:0] L_A1   = 10'(ACT1);
   localparam logic [9:0] L_V2   = 10'(V2_FIRST);
   localparam logic [9:0] L_A2   = 10'(ACT2);
   localparam logic [9:0] L_LAST = 10'(V_TOTAL);

   localparam logic [7:0] FILL_C = 8'h80;
   localparam logic [7:0] FILL_Y = 8'h10;

   logic [HW-1:0] h_q, h_d;
   logic [9:0]    line_q, line_d;
   logic [7:0]    td_q, td_d;
   logic [7:0]    yh_q, yh_d;
   logic          req_q, req_d;
   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          fld_q, fld_d;
   logic          unf_q, unf_d;

   logic          h_wrap;
   logic          f_bit, v_bit;
   logic          in_eav, in_fill, in_sav, in_act;
   logic [1:0]    sav_idx;
   logic [HW-1:0] rel_act;

   function automatic logic [7:0] clip(input logic [7:0] b);
      logic [7:0] r;
      r = b;
      if (b == 8'h00) r = 8'h01;
      if (b == 8'hFF) r = 8'hFE;
      return r;
   endfunction

   function automatic logic [7:0] tcode(
      input logic [1:0] idx,
      input logic       f,
      input logic       v,
      input logic       h
   );
      logic [7:0] r;
      unique case (idx)
         2'd0:    r = 8'hFF;
         2'd3:    r = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   always_comb begin
      h_wrap = (h_q == H_LAST);
      h_d    = h_wrap ? '0 : h_q + HW'(1);
      line_d = line_q;
      if (h_wrap) begin
         line_d = (line_q == L_LAST) ? 10'd1 : line_q + 10'd1;
      end

      f_bit = (line_q < L_F0) || (line_q >= L_F1);
      v_bit = !(((line_q >= L_A1) && (line_q < L_V2)) ||
                (line_q >= L_A2));

      in_eav  = (h_q < H_FILL);
      in_fill = (h_q >= H_FILL) && (h_q < H_SAV);
      in_sav  = (h_q >= H_SAV) && (h_q < H_ACT);
      in_act  = (h_q >= H_ACT);
      sav_idx = h_q[1:0] - H_SAV[1:0];
      rel_act = h_q - H_ACT;

      td_d  = FILL_C;
      yh_d  = yh_q;
      unf_d = unf_q;
      x_d   = '0;

      unique case (1'b1)
         in_eav:  td_d = tcode(h_q[1:0], f_bit, v_bit, 1'b1);
         // fill starts at h=4, so parity of h gives Cb/Cr vs Y
         in_fill: td_d = h_q[0] ? FILL_Y : FILL_C;
         in_sav:  td_d = tcode(sav_idx, f_bit, v_bit, 1'b0);
         in_act: begin
            x_d = 10'(rel_act >> 1);
            if (v_bit) begin
               td_d = rel_act[0] ? FILL_Y : FILL_C;
            end else if (rel_act[0]) begin
               td_d = yh_q;
            end else if (iDVAL) begin
               // FIFO word arrives in the C slot; hold Y for next byte
               td_d = clip(iYCbCr[7:0]);
               yh_d = clip(iYCbCr[15:8]);
            end else begin
               td_d  = FILL_C;
               yh_d  = FILL_Y;
               unf_d = 1'b1;
            end
         end
         default: td_d = FILL_C;
      endcase

      req_d = !v_bit && (h_q >= H_RQ0) && (h_q <= H_RQN) &&
              (h_q[0] == H_RQ0[0]);
      y_d   = line_q;
      hs_d  = !in_act;
      vs_d  = v_bit;
      fld_d = f_bit;
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         h_q    <= '0;
         line_q <= 10'd1;
         td_q   <= FILL_C;
         yh_q   <= FILL_Y;
         req_q  <= 1'b0;
         x_q    <= '0;
         y_q    <= 10'd1;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
         fld_q  <= 1'b1;
         unf_q  <= 1'b0;
      end else begin
         h_q    <= h_d;
         line_q <= line_d;
         td_q   <= td_d;
         yh_q   <= yh_d;
         req_q  <= req_d;
         x_q    <= x_d;
         y_q    <= y_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         fld_q  <= fld_d;
         unf_q  <= unf_d;
      end
   end

   assign oTD_DATA   = td_q;
   assign oRequest   = req_q;
   assign oTV_X      = x_q;
   assign oTV_Y      = y_q;
   assign oHS        = hs_q;
   assign oVS        = vs_q;
   assign oField     = fld_q;
   assign oUnderflow = unf_q;

endmodule

// File: tb/tb_itu656_encoder.sv
// tb_itu656_encoder: bench for itu656_encoder with a short line
// (H_ACTIVE=20, H_BLANK=12) and the full 525-line frame.
`timescale 1ns/1ps

module tb_itu656_encoder;

   localparam int HA    = 20;
   localparam int HB    = 12;
   localparam int VT    = 525;
   localparam int A0    = 8 + HB;
   localparam int LL    = A0 + 2 * HA;
   localparam int FRAME = VT * LL;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ycc = '0;
   logic        dval = 1'b0;
   logic        oRequest;
   logic [7:0]  oTD_DATA;
   logic [9:0]  oTV_X;
   logic [9:0]  oTV_Y;
   logic        oHS, oVS, oField, oUnderflow;

   itu656_encoder #(.H_ACTIVE(HA), .H_BLANK(HB)) dut (
      .iCLK(clk),
      .iRST(rst),
      .iYCbCr(ycc),
      .iDVAL(dval),
      .oRequest(oRequest),
      .oTD_DATA(oTD_DATA),
      .oTV_X(oTV_X),
      .oTV_Y(oTV_Y),
      .oHS(oHS),
      .oVS(oVS),
      .oField(oField),
      .oUnderflow(oUnderflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         ln;
      logic [7:0] sav;
      logic [7:0] eav;
      logic       f;
      logic       v;
   } tv_t;

   tv_t tbl [12];

   int errs = 0;
   int checks = 0;

   int         n;
   logic       req_prev;
   logic       exp_unf;
   logic [7:0] pc [HA];
   logic [7:0] py [HA];
   logic       pdv [HA];
   int         req_frame;
   int         bad_code;
   int         req_line [1:VT];
   logic [7:0] sav_cap [1:VT];
   logic [7:0] eav_cap [1:VT];
   logic       fcap [1:VT];
   logic       vcap [1:VT];
   logic [7:0] lb  [LL];
   logic [7:0] l20 [LL];
   logic [7:0] l21 [LL];
   logic [7:0] l50 [LL];

   logic [7:0] eav1 [4] = '{8'hFF, 8'h00, 8'h00, 8'hF1};
   logic [7:0] sav1 [4] = '{8'hFF, 8'h00, 8'h00, 8'hEC};

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic f_of(input int ln);
      return (ln < 4) || (ln >= 266);
   endfunction

   function automatic logic v_of(input int ln);
      return !((ln >= 20 && ln <= 263) || (ln >= 283));
   endfunction

   function automatic logic [7:0] xy_of(input int ln, input logic h);
      logic f, v;
      f = f_of(ln);
      v = v_of(ln);
      return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
   endfunction

   function automatic logic [7:0] clip(input logic [7:0] b);
      if (b == 8'h00) return 8'h01;
      if (b == 8'hFF) return 8'hFE;
      return b;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_td"}, oTD_DATA, 8'h80);
      chk({tag, "_req"}, oRequest, 1'b0);
      chk({tag, "_x"}, oTV_X, 10'd0);
      chk({tag, "_y"}, oTV_Y, 10'd1);
      chk({tag, "_hs"}, oHS, 1'b1);
      chk({tag, "_vs"}, oVS, 1'b1);
      chk({tag, "_fld"}, oField, 1'b1);
      chk({tag, "_unf"}, oUnderflow, 1'b0);
   endtask

   // One byte period: compare every output with the model, then
   // act as the FIFO for a request seen one byte earlier.
   task automatic step();
      int ln, h, s, a, k, ln2, h2, ln1, h1, k1;
      logic [7:0] e_td, c, y;
      logic e_req, dv;
      logic [32:0] got, exp;
      @(posedge clk);
      #1;
      ln = (n / LL) % VT + 1;
      h  = n % LL;
      if (h == 0) e_td = 8'hFF;
      else if (h < 3) e_td = 8'h00;
      else if (h == 3) e_td = xy_of(ln, 1'b1);
      else if (h < 4 + HB) e_td = ((h - 4) % 2 != 0) ? 8'h10 : 8'h80;
      else if (h < A0) begin
         s = h - (4 + HB);
         if (s == 0) e_td = 8'hFF;
         else if (s < 3) e_td = 8'h00;
         else e_td = xy_of(ln, 1'b0);
      end else begin
         a = h - A0;
         k = a / 2;
         if (v_of(ln)) e_td = (a % 2 != 0) ? 8'h10 : 8'h80;
         else if (a % 2 == 0) begin
            if (pdv[k]) e_td = clip(pc[k]);
            else begin
               e_td = 8'h80;
               exp_unf = 1'b1;
            end
         end else e_td = pdv[k] ? clip(py[k]) : 8'h10;
      end
      ln2 = ((n + 2) / LL) % VT + 1;
      h2  = (n + 2) % LL;
      e_req = !v_of(ln2) && h2 >= A0 && ((h2 - A0) % 2 == 0);
      got = {oTD_DATA, oRequest, oTV_X, oTV_Y,
             oHS, oVS, oField, oUnderflow};
      exp = {e_td, e_req, (h >= A0) ? 10'((h - A0) / 2) : 10'd0,
             10'(ln), (h < A0), v_of(ln), f_of(ln), exp_unf};
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL stream n=%0d line=%0d h=%0d got %09h expected %09h",
                  n, ln, h, got, exp);
      end
      lb[h] = oTD_DATA;
      if (n < FRAME) begin
         if (oRequest) begin
            req_line[ln]++;
            req_frame++;
         end
         if ((oTD_DATA == 8'hFF || oTD_DATA == 8'h00) &&
             !(h < 4 || (h >= A0 - 4 && h < A0)))
            bad_code++;
         if (h == 3) eav_cap[ln] = oTD_DATA;
         if (h == A0 - 1) sav_cap[ln] = oTD_DATA;
         if (h == 0) begin
            fcap[ln] = oField;
            vcap[ln] = oVS;
         end
         if (h == LL - 1) begin
            if (ln == 20) l20 = lb;
            if (ln == 21) l21 = lb;
            if (ln == 50) l50 = lb;
         end
      end
      if (req_prev) begin
         ln1 = ((n + 1) / LL) % VT + 1;
         h1  = (n + 1) % LL;
         k1  = (h1 - A0) / 2;
         {y, c} = 16'($urandom);
         dv = 1'b1;
         if (ln1 == 20) begin
            c = 8'h40 + 8'(k1);
            y = 8'(k1);
         end else if (ln1 == 21 && k1 == 0) begin
            c = 8'h00;
            y = 8'hFF;
         end else if (ln1 == 21 && k1 == 1) begin
            c = 8'hFF;
            y = 8'h00;
         end else if (ln1 == 50 && k1 == 10) begin
            dv = 1'b0;
         end
         if (h1 >= A0 && ((h1 - A0) % 2 == 0)) begin
            pc[k1]  = c;
            py[k1]  = y;
            pdv[k1] = dv;
         end
         ycc  = {y, c};
         dval = dv;
      end else begin
         ycc  = 16'($urandom);
         dval = 1'b0;
      end
      req_prev = oRequest;
      n++;
   endtask

   initial begin
      tbl[0]  = '{1,   8'hEC, 8'hF1, 1'b1, 1'b1};
      tbl[1]  = '{3,   8'hEC, 8'hF1, 1'b1, 1'b1};
      tbl[2]  = '{4,   8'hAB, 8'hB6, 1'b0, 1'b1};
      tbl[3]  = '{19,  8'hAB, 8'hB6, 1'b0, 1'b1};
      tbl[4]  = '{20,  8'h80, 8'h9D, 1'b0, 1'b0};
      tbl[5]  = '{263, 8'h80, 8'h9D, 1'b0, 1'b0};
      tbl[6]  = '{264, 8'hAB, 8'hB6, 1'b0, 1'b1};
      tbl[7]  = '{265, 8'hAB, 8'hB6, 1'b0, 1'b1};
      tbl[8]  = '{266, 8'hEC, 8'hF1, 1'b1, 1'b1};
      tbl[9]  = '{282, 8'hEC, 8'hF1, 1'b1, 1'b1};
      tbl[10] = '{283, 8'hC7, 8'hDA, 1'b1, 1'b0};
      tbl[11] = '{525, 8'hC7, 8'hDA, 1'b1, 1'b0};

      for (int i = 0; i < HA; i++) begin
         pc[i]  = 8'h80;
         py[i]  = 8'h10;
         pdv[i] = 1'b1;
      end
      for (int i = 1; i <= VT; i++) req_line[i] = 0;
      req_frame = 0;
      bad_code  = 0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      req_prev = 1'b0;
      exp_unf = 1'b0;

      for (int i = 0; i < 4; i++) begin
         step();
         chk("first_eav", oTD_DATA, eav1[i]);
      end
      repeat (LL - 4) step();
      chk("l1_fill0", lb[4], 8'h80);
      chk("l1_fill1", lb[5], 8'h10);
      chk("l1_filln", lb[A0 - 5], 8'h10);
      for (int i = 0; i < 4; i++) chk("l1_sav", lb[A0 - 4 + i], sav1[i]);
      chk("l1_req", req_line[1], 0);

      repeat (FRAME - LL) step();
      step();
      chk("wrap_y", oTV_Y, 10'd1);
      chk("wrap_eav", oTD_DATA, 8'hFF);
      chk("unf_held", oUnderflow, 1'b1);
      chk("frame_req", req_frame, 487 * HA);
      chk("l20_req", req_line[20], HA);
      chk("l20_c0", l20[A0], 8'h40);
      chk("l20_y0", l20[A0 + 1], 8'h01);
      chk("l20_c1", l20[A0 + 2], 8'h41);
      chk("l20_y1", l20[A0 + 3], 8'h01);
      chk("l20_cn", l20[LL - 2], 8'h40 + 8'(HA - 1));
      chk("l20_yn", l20[LL - 1], 8'(HA - 1));
      chk("clip_c0", l21[A0], 8'h01);
      chk("clip_y0", l21[A0 + 1], 8'hFE);
      chk("clip_c1", l21[A0 + 2], 8'hFE);
      chk("clip_y1", l21[A0 + 3], 8'h01);
      chk("no_ff00", bad_code, 0);
      chk("unf_c", l50[A0 + 20], 8'h80);
      chk("unf_y", l50[A0 + 21], 8'h10);

      for (int i = 0; i < 12; i++) begin
         chk($sformatf("sav_l%0d", tbl[i].ln), sav_cap[tbl[i].ln], tbl[i].sav);
         chk($sformatf("eav_l%0d", tbl[i].ln), eav_cap[tbl[i].ln], tbl[i].eav);
         chk($sformatf("f_l%0d", tbl[i].ln), fcap[tbl[i].ln], tbl[i].f);
         chk($sformatf("v_l%0d", tbl[i].ln), vcap[tbl[i].ln], tbl[i].v);
      end

      while (n <= FRAME + 99 * LL + 40) step();
      chk("pre_rst_y", oTV_Y, 10'd100);
      #3;
      rst = 1'b1;
      #1;
      chk_reset("async");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      dval = 1'b0;
      n = 0;
      req_prev = 1'b0;
      exp_unf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("restart_eav", oTD_DATA, eav1[i]);
      end
      repeat (2 * LL) step();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
